lcd_bank_sched: RTL
===================

LCD_BANK_SCHED -- requirements
Module: lcd_bank_sched

Interface
REQ-001 SHALL have parameter FRAME_PIX, default 23040, meaning pixels per complete frame (160x144).
REQ-002 SHALL have parameter RD_AHEAD, default 9600, meaning the minimum write count (160x60) at which the reader may share the write bank.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ce, input, 1, clock enable qualifying wr_pix.
REQ-006 SHALL have port wr_frame_start, input, 1, one-cycle pulse when the writer begins a frame.
REQ-007 SHALL have port wr_pix, input, 1, pixel-write request, valid only when ce=1.
REQ-008 SHALL have port rd_frame_start, input, 1, one-cycle pulse when the reader begins a frame.
REQ-009 SHALL have port double_buffer, input, 1, enabling bank selection; when 0, the reader follows the write bank.
REQ-010 SHALL have port freeze, input, 1, suppressing all writes.
REQ-011 SHALL have port wr_en, output, 1, write strobe to the frame buffer.
REQ-012 SHALL have port wr_addr, output, 16, {wr_bank, wr_ptr[14:0]}.
REQ-013 SHALL have port rd_bank, output, 1, bank the reader uses for the current frame.
REQ-014 SHALL have port rd_valid, output, 1, indicating that rd_bank holds displayable data; the reader outputs blank when it is 0.
REQ-015 SHALL have port drop_cnt, output, 8, saturating count of abandoned partial frames.

Function
REQ-016 SHALL implement states ST_EMPTY, ST_RUN and ST_FREEZE.
REQ-017 wr_en SHALL equal ce & wr_pix & ~freeze & (wr_ptr < FRAME_PIX), combinationally.
REQ-018 wr_ptr SHALL increment by 1 in the cycle following each wr_en; it holds at FRAME_PIX and never wraps.
REQ-019 frame_done SHALL be defined as wr_ptr == FRAME_PIX.
REQ-020 When frame_done is first reached, last_bank SHALL be set to wr_bank, and the state SHALL move from ST_EMPTY to ST_RUN.
REQ-021 On wr_frame_start with freeze=0, wr_ptr SHALL clear to 0, and wr_bank SHALL toggle if and only if frame_done=1.
REQ-022 On wr_frame_start with freeze=0, if 0 < wr_ptr < FRAME_PIX, drop_cnt SHALL increment, saturating at 255; the bank SHALL be kept and overwritten.
REQ-023 On wr_frame_start with freeze=1, the block SHALL ignore the pulse: no pointer clear, no toggle, no drop count.
REQ-024 In ST_RUN, freeze=1 SHALL enter ST_FREEZE.
REQ-025 ST_FREEZE SHALL exit to ST_RUN on the first wr_frame_start with freeze=0; that partial-frame handling follows REQ-021 and REQ-022.
REQ-026 In ST_EMPTY, freeze SHALL only gate wr_en, with no state change.
REQ-027 On rd_frame_start, rd_bank SHALL be set to wr_bank if double_buffer=0 or wr_ptr >= RD_AHEAD; otherwise it SHALL be set to last_bank.
REQ-028 rd_bank SHALL change only on rd_frame_start.
REQ-029 rd_valid SHALL be set to 0 on rd_frame_start in ST_EMPTY, and to 1 on rd_frame_start in ST_RUN or ST_FREEZE.
REQ-030 On a simultaneous rd_frame_start and wr_frame_start, the rd_bank decision SHALL use the pre-update wr_bank and wr_ptr.
REQ-031 When wr_en coincides with wr_frame_start, wr_frame_start SHALL take priority: the pointer clears and the write is lost.
REQ-032 The rd_bank and rd_valid decision SHALL take effect the cycle after rd_frame_start.
REQ-033 wr_addr SHALL be combinational from registers.

Reset
REQ-034 While reset=1, the block SHALL enter ST_EMPTY and clear wr_ptr, wr_bank, last_bank, rd_bank, rd_valid and drop_cnt to 0.
REQ-035 The reset values SHALL hold in the first cycle after reset deasserts.
REQ-036 Reset mid-frame SHALL discard the partial frame without incrementing drop_cnt.
REQ-037 Pulses coincident with reset SHALL be ignored.

Structure
REQ-038 The shared lcd_pkg SHALL hold the state enum, LCD_W=160, LCD_H=144, FRAME_PIX and RD_AHEAD.
REQ-039 The write-pointer counter with saturation and frame_done SHALL be the single sub-module lcd_wr_ptr.
REQ-040 The state machine and rd_bank select SHALL reside in the top module.

Verification
REQ-041 Bench SHALL cover: reset, then 23040 wr_pix with ce=1, then wr_frame_start -> wr_bank=1, last_bank=0, state ST_RUN, wr_ptr=0.
REQ-042 Bench SHALL cover: double_buffer=1, wr_ptr=5000, rd_frame_start -> rd_bank=last_bank, rd_valid=1; repeat at wr_ptr=9600 -> rd_bank=wr_bank.
REQ-043 Bench SHALL cover: wr_frame_start at wr_ptr=100 -> drop_cnt increments by 1, wr_bank unchanged; 300 such events -> drop_cnt=255.
REQ-044 Bench SHALL cover: freeze=1 in ST_RUN, 50 wr_pix and a wr_frame_start -> wr_en=0 throughout, wr_ptr unchanged; freeze=0 then wr_frame_start -> ST_RUN.
REQ-045 Bench SHALL cover: rd_frame_start in ST_EMPTY -> rd_valid=0; 23041 wr_pix -> wr_ptr stops at 23040, the last wr_en=0.
REQ-046 Bench SHALL cover: simultaneous rd_frame_start and wr_frame_start with frame_done=1, wr_bank=0, double_buffer=1 -> rd_bank=0, wr_bank=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and geometry for the LCD frame-buffer bank scheduler.
package lcd_pkg;

  localparam int LCD_W     = 160;
  localparam int LCD_H     = 144;
  localparam int FRAME_PIX = LCD_W * LCD_H;
  localparam int RD_AHEAD  = LCD_W * 60;
  localparam int PTR_W     = 15;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } lcd_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lcd_bank_sched_if.sv
// Handshake/bus bundle between the LCD pixel writer, frame buffer and reader.
interface lcd_bank_sched_if;
  logic        ce;
  logic        wr_frame_start;
  logic        wr_pix;
  logic        rd_frame_start;
  logic        double_buffer;
  logic        freeze;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic        rd_bank;
  logic        rd_valid;
  logic [7:0]  drop_cnt;

  modport slave (
    input  ce, wr_frame_start, wr_pix, rd_frame_start, double_buffer, freeze,
    output wr_en, wr_addr, rd_bank, rd_valid, drop_cnt
  );

  modport master (
    output ce, wr_frame_start, wr_pix, rd_frame_start, double_buffer, freeze,
    input  wr_en, wr_addr, rd_bank, rd_valid, drop_cnt
  );
endinterface

// File: rtl/lcd_wr_ptr.sv
// Frame write pointer: saturates at FRAME_PIX, restart has priority over increment.
module lcd_wr_ptr
  import lcd_pkg::*;
#(
  parameter int FRAME_PIX = lcd_pkg::FRAME_PIX
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr,
  output logic             frame_done,
  output logic             done_hit
);

  localparam logic [PTR_W-1:0] FULL_C    = PTR_W'(FRAME_PIX);
  localparam logic [PTR_W-1:0] FULL_M1_C = PTR_W'(FRAME_PIX - 1);
  localparam logic [PTR_W-1:0] ONE_C     = PTR_W'(1);

  logic [PTR_W-1:0] ptr_r;

  // pointer register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (clr) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (inc && (ptr_r != FULL_C)) begin
      ptr_r <= ptr_r + ONE_C;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr        = ptr_r;
  assign frame_done = (ptr_r == FULL_C);
  // high in the cycle whose write completes the frame
  assign done_hit   = inc && !clr && (ptr_r == FULL_M1_C);

endmodule

// File: rtl/lcd_bank_sched.sv
// LCD frame-buffer bank scheduler: write addressing, frame drop accounting and reader bank choice.
module lcd_bank_sched
  import lcd_pkg::*;
#(
  parameter int FRAME_PIX = lcd_pkg::FRAME_PIX,
  parameter int RD_AHEAD  = lcd_pkg::RD_AHEAD
) (
  input  logic              clk_sys,
  input  logic              reset,
  lcd_bank_sched_if.slave   bus
);

  localparam logic [PTR_W-1:0] FULL_C  = PTR_W'(FRAME_PIX);
  localparam logic [PTR_W-1:0] AHEAD_C = PTR_W'(RD_AHEAD);

  lcd_state_e       state_r, state_nx_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic             frame_done_s, done_hit_s, wr_en_s, wr_restart_s;
  logic             show_s, capture_last_s;
  logic             wr_bank_r, last_bank_r, rd_bank_r, rd_valid_r;
  logic [7:0]       drop_cnt_r;

  assign wr_restart_s = bus.wr_frame_start & ~bus.freeze;
  assign wr_en_s      = bus.ce & bus.wr_pix & ~bus.freeze & (wr_ptr_s < FULL_C);

  lcd_wr_ptr #(.FRAME_PIX(FRAME_PIX)) u_wr_ptr (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .inc        (wr_en_s),
    .clr        (wr_restart_s),
    .ptr        (wr_ptr_s),
    .frame_done (frame_done_s),
    .done_hit   (done_hit_s)
  );

  // state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_r <= ST_EMPTY;
    else       state_r <= state_nx_s;
  end

  // next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_EMPTY:  if (done_hit_s)   state_nx_s = ST_RUN;    else state_nx_s = ST_EMPTY;
      ST_RUN:    if (bus.freeze)   state_nx_s = ST_FREEZE; else state_nx_s = ST_RUN;
      ST_FREEZE: if (wr_restart_s) state_nx_s = ST_RUN;    else state_nx_s = ST_FREEZE;
      default:                     state_nx_s = ST_EMPTY;
    endcase
  end

  // state-derived controls
  always_comb begin
    show_s         = 1'b0;
    capture_last_s = done_hit_s;
    case (state_r)
      ST_EMPTY:  show_s = 1'b0;
      ST_RUN:    show_s = 1'b1;
      ST_FREEZE: show_s = 1'b1;
      default:   show_s = 1'b0;
    endcase
  end

  // write-side bank, last complete bank and abandoned-frame count
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_bank_r   <= 1'b0;
      last_bank_r <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      wr_bank_r   <= (wr_restart_s && frame_done_s) ? ~wr_bank_r : wr_bank_r;
      last_bank_r <= capture_last_s ? wr_bank_r : last_bank_r;
      if (wr_restart_s && !frame_done_s && (wr_ptr_s != {PTR_W{1'b0}})) begin
        drop_cnt_r <= sat_inc8(drop_cnt_r);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // reader bank decision uses the pre-update write bank/pointer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_bank_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else if (bus.rd_frame_start) begin
      rd_bank_r  <= (!bus.double_buffer || (wr_ptr_s >= AHEAD_C)) ? wr_bank_r : last_bank_r;
      rd_valid_r <= show_s;
    end else begin
      rd_bank_r  <= rd_bank_r;
      rd_valid_r <= rd_valid_r;
    end
  end

  assign bus.wr_en    = wr_en_s;
  assign bus.wr_addr  = {wr_bank_r, wr_ptr_s};
  assign bus.rd_bank  = rd_bank_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.drop_cnt = drop_cnt_r;

endmodule
